// File: rtl/sext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sext_pkg
// Purpose  : Shared definitions for the sign-extension compressing serializer:
//            word/half widths, serializer state encoding and the
//            "is this word a 16->32 sign extension" test.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sext_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_EXT = 2'd1,
    SEND_HI  = 2'd2,
    SEND_LO  = 2'd3
  } state_t;

  // A word is compressible when bits [31:15] are all equal: the upper half is
  // then fully determined by bit 15 of the lower half.
  function automatic logic is_sext16(input logic [WORD_W-1:0] word);
    return (word[WORD_W-1:HALF_W-1] == '0) || (word[WORD_W-1:HALF_W-1] == '1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Event counter that sticks at all-ones instead of wrapping.
// Ports    : clk      - clock, rising edge
//            i_clear  - synchronous clear (highest priority)
//            i_inc    - count one event this cycle
//            o_count  - current count
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/sext_compress_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sext_compress_serializer
// Purpose  : Serializes 32-bit words onto a 16-bit stream. A word that is the
//            sign extension of its low half is sent as one tagged beat
//            (out_ext=1); any other word is sent as two raw beats, high half
//            first. Optional feature macro: SEXT_COMPRESS_EN (undefined: every
//            word takes two beats, out_ext and cnt_comp stay 0).
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous active-low reset
//            in_valid   - producer presents in_data
//            in_ready   - block accepts in_data this cycle
//            in_data    - 32-bit word to serialize
//            out_valid  - out_data/out_ext/out_last valid
//            out_ready  - consumer accepts the current beat
//            out_data   - 16-bit beat payload
//            out_ext    - beat is a compressed word (sign-extend to rebuild)
//            out_last   - final beat of the current word
//            cnt_words  - words accepted since reset (saturating)
//            cnt_comp   - words sent compressed since reset (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module sext_compress_serializer
  import sext_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HALF_W-1:0] out_data,
  output logic              out_ext,
  output logic              out_last,
  output logic [CNT_W-1:0]  cnt_words,
  output logic [CNT_W-1:0]  cnt_comp
);

  state_t            r_state;
  logic [HALF_W-1:0] r_hold;
  logic              r_out_valid;
  logic [HALF_W-1:0] r_out_data;
  logic              r_out_ext;
  logic              r_out_last;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_comp;

`ifdef SEXT_COMPRESS_EN
  assign w_comp = is_sext16(in_data);
`else
  assign w_comp = 1'b0;
`endif

  // A final beat (EXT or LO) frees the output register in the same cycle it
  // is consumed, so a new word can be taken without a bubble.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      IDLE:     w_in_ready = 1'b1;
      SEND_EXT: w_in_ready = out_ready;
      SEND_HI:  w_in_ready = 1'b0;
      SEND_LO:  w_in_ready = out_ready;
      default:  w_in_ready = 1'b0;
    endcase
  end

  assign w_accept = in_valid & w_in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ext   <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_out_valid <= 1'b0;
        end
        SEND_EXT, SEND_LO: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        SEND_HI: begin
          if (out_ready) begin
            r_state    <= SEND_LO;
            r_out_data <= r_hold;
            r_out_ext  <= 1'b0;
            r_out_last <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase

      // Accepting a word overrides the transitions above; acceptance is only
      // possible in IDLE or while a final beat is being consumed.
      if (w_accept) begin
        r_hold      <= in_data[HALF_W-1:0];
        r_out_valid <= 1'b1;
        if (w_comp) begin
          r_state    <= SEND_EXT;
          r_out_data <= in_data[HALF_W-1:0];
          r_out_ext  <= 1'b1;
          r_out_last <= 1'b1;
        end else begin
          r_state    <= SEND_HI;
          r_out_data <= in_data[WORD_W-1:HALF_W];
          r_out_ext  <= 1'b0;
          r_out_last <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ext   = r_out_ext;
  assign out_last  = r_out_last;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_words (
    .clk     (clk),
    .i_clear (~rst_n),
    .i_inc   (w_accept),
    .o_count (cnt_words)
  );

`ifdef SEXT_COMPRESS_EN
  sat_counter #(.CNT_W(CNT_W)) u_cnt_comp (
    .clk     (clk),
    .i_clear (~rst_n),
    .i_inc   (w_accept & w_comp),
    .o_count (cnt_comp)
  );
`else
  assign cnt_comp = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sext_compress_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sext_compress_serializer
// Purpose  : Self-checking bench for sext_compress_serializer: directed
//            vector table, multi-cycle corner sequences and a randomized run
//            against a queue-based reference model of the beat stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sext_compress_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ext;
  logic        out_last;
  logic [15:0] cnt_words;
  logic [15:0] cnt_comp;

  // second instance with narrow counters for saturation
  logic        s_in_valid;
  logic        s_in_ready;
  logic [31:0] s_in_data;
  logic        s_out_valid;
  logic [15:0] s_out_data;
  logic        s_out_ext;
  logic        s_out_last;
  logic [1:0]  s_cnt_words;
  logic [1:0]  s_cnt_comp;

  always #5 clk = ~clk;

  sext_compress_serializer #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ext(out_ext), .out_last(out_last),
    .cnt_words(cnt_words), .cnt_comp(cnt_comp)
  );

  sext_compress_serializer #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
    .out_ext(s_out_ext), .out_last(s_out_last),
    .cnt_words(s_cnt_words), .cnt_comp(s_cnt_comp)
  );

`ifdef SEXT_COMPRESS_EN
  localparam bit COMP_ON = 1'b1;
`else
  localparam bit COMP_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] signExtend16to32(input logic [15:0] x);
    return {{16{x[15]}}, x};
  endfunction

  function automatic bit compressible(input logic [31:0] w);
    return COMP_ON && (signExtend16to32(w[15:0]) == w);
  endfunction

  // ---------------- reference model and monitor ----------------
  typedef struct {
    logic [15:0] data;
    logic        ext;
    logic        last;
    logic [31:0] word;
  } beat_t;

  typedef struct {
    logic [15:0] data;
    logic        ext;
    logic        last;
    int          cyc;
  } log_t;

  beat_t exp_q[$];
  log_t  beat_log[$];
  int    exp_words = 0;
  int    exp_comp  = 0;
  bit    mon_en = 0;
  logic  rst_q;
  bit    prev_stall = 0;
  logic [15:0] prev_data;
  logic        prev_ext, prev_last;

  always @(posedge clk) begin
    rst_q <= rst_n;
    cyc   <= cyc + 1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_q) begin
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_ext_last", {30'd0, out_ext, out_last}, 32'd0);
        chk("rst_cnt_words", {16'd0, cnt_words}, 32'd0);
        chk("rst_cnt_comp", {16'd0, cnt_comp}, 32'd0);
        exp_q.delete();
        exp_words = 0;
        exp_comp  = 0;
      end else begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        chk("in_ready", {31'd0, in_ready},
            {31'd0, (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)});
        if (out_valid && exp_q.size() != 0) begin
          chk("beat_data", {16'd0, out_data}, {16'd0, exp_q[0].data});
          chk("beat_ext_last", {30'd0, out_ext, out_last}, {30'd0, exp_q[0].ext, exp_q[0].last});
          if (out_ext) chk("sext_rebuild", signExtend16to32(out_data), exp_q[0].word);
        end
        if (prev_stall)
          chk("stall_stable", {14'd0, out_data, out_ext, out_last}, {14'd0, prev_data, prev_ext, prev_last});
        chk("cnt_words", {16'd0, cnt_words}, exp_words);
        chk("cnt_comp", {16'd0, cnt_comp}, exp_comp);
      end
      // effects of the coming edge (reset pending overrides them)
      if (rst_n) begin
        if (out_valid && out_ready && exp_q.size() != 0) begin
          beat_log.push_back('{out_data, out_ext, out_last, cyc});
          void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
          if (exp_words < 65535) exp_words++;
          if (compressible(in_data)) begin
            if (exp_comp < 65535) exp_comp++;
            exp_q.push_back('{in_data[15:0], 1'b1, 1'b1, in_data});
          end else begin
            exp_q.push_back('{in_data[31:16], 1'b0, 1'b0, in_data});
            exp_q.push_back('{in_data[15:0], 1'b0, 1'b1, in_data});
          end
        end
      end
      prev_stall = rst_n && out_valid && !out_ready;
      prev_data  = out_data;
      prev_ext   = out_ext;
      prev_last  = out_last;
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  logic [31:0] stream_buf[8];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_stream(input int n);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 200) begin
      in_valid = 1'b1;
      in_data  = stream_buf[i];
      @(negedge clk);
      if (in_ready) i++;
      next_cycle();
      guard++;
    end
    in_valid = 1'b0;
    if (i < n) chk("send_timeout", i, n);
  endtask

  task automatic wait_beats(input int n);
    int guard = 0;
    while (beat_log.size() < n && guard < 200) begin
      next_cycle();
      guard++;
    end
    if (beat_log.size() < n) chk("beat_timeout", beat_log.size(), n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] word;
    int          nb;
    logic [15:0] b0;
    logic [15:0] b1;
    logic        ext;
  } vec_t;

  vec_t tbl[7];

  function automatic vec_t mk(input logic [31:0] w, input bit comp);
    vec_t v;
    v.word = w;
    if (comp && COMP_ON) begin
      v.nb = 1; v.b0 = w[15:0]; v.b1 = 16'h0; v.ext = 1'b1;
    end else begin
      v.nb = 2; v.b0 = w[31:16]; v.b1 = w[15:0]; v.ext = 1'b0;
    end
    return v;
  endfunction

  initial begin
    logic [15:0] cc_before;
    int acc;
    int guard;

    tbl[0] = mk(32'h00007B95, 1);
    tbl[1] = mk(32'hFFFFFB95, 1);
    tbl[2] = mk(32'h00008000, 0);  // bit 15 set, upper zero
    tbl[3] = mk(32'hFFFF7FFF, 0);  // bit 15 clear, upper ones
    tbl[4] = mk(32'h00000000, 1);
    tbl[5] = mk(32'hFFFF8000, 1);
    tbl[6] = mk(32'h7FFFFFFF, 0);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0;
    next_cycle();
    mon_en = 1;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // table: one word at a time, consumer always ready
    for (int i = 0; i < 7; i++) begin
      beat_log.delete();
      stream_buf[0] = tbl[i].word;
      send_stream(1);
      wait_beats(tbl[i].nb);
      repeat (2) next_cycle();
      chk("tbl_nbeats", beat_log.size(), tbl[i].nb);
      if (beat_log.size() >= 1) begin
        chk("tbl_b0", {16'd0, beat_log[0].data}, {16'd0, tbl[i].b0});
        chk("tbl_b0_ext_last", {30'd0, beat_log[0].ext, beat_log[0].last},
            {30'd0, tbl[i].ext, tbl[i].nb == 1});
      end
      if (tbl[i].nb == 2 && beat_log.size() >= 2) begin
        chk("tbl_b1", {16'd0, beat_log[1].data}, {16'd0, tbl[i].b1});
        chk("tbl_b1_ext_last", {30'd0, beat_log[1].ext, beat_log[1].last}, 32'd1);
      end
    end
    chk("tbl_cnt_comp", {16'd0, cnt_comp}, COMP_ON ? 32'd4 : 32'd0);

    // stall on the high half
    beat_log.delete();
    cc_before = cnt_comp;
    out_ready = 1'b0;
    stream_buf[0] = 32'h12348000;
    send_stream(1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_hi_beat", {13'd0, out_valid, out_data, out_ext, out_last},
          {13'd0, 1'b1, 16'h1234, 1'b0, 1'b0});
      next_cycle();
    end
    out_ready = 1'b1;
    wait_beats(2);
    if (beat_log.size() >= 2) begin
      chk("stall_b0", {14'd0, beat_log[0].data, beat_log[0].ext, beat_log[0].last}, {14'd0, 16'h1234, 2'b00});
      chk("stall_b1", {14'd0, beat_log[1].data, beat_log[1].ext, beat_log[1].last}, {14'd0, 16'h8000, 2'b01});
    end
    chk("stall_cnt_comp", {16'd0, cnt_comp}, {16'd0, cc_before});

    // reset while sitting in SEND_HI: the low half must never appear
    next_cycle();
    beat_log.delete();
    out_ready = 1'b0;
    stream_buf[0] = 32'hABCD1234;
    send_stream(1);
    next_cycle();
    do_reset();
    out_ready = 1'b1;
    repeat (4) next_cycle();
    chk("rst_no_lo_beat", beat_log.size(), 0);
    chk("rst_cnt_after", {cnt_words, cnt_comp}, 32'd0);

    // back-to-back stream, no bubbles
    beat_log.delete();
    stream_buf[0] = 32'h00000001;
    stream_buf[1] = 32'hFFFFFFFF;
    stream_buf[2] = 32'h00010000;
    send_stream(3);
    wait_beats(COMP_ON ? 4 : 6);
    next_cycle();
    if (COMP_ON) begin
      chk("b2b_nbeats", beat_log.size(), 4);
      if (beat_log.size() >= 4) begin
        chk("b2b_0", {15'd0, beat_log[0].data, beat_log[0].ext}, {15'd0, 16'h0001, 1'b1});
        chk("b2b_1", {15'd0, beat_log[1].data, beat_log[1].ext}, {15'd0, 16'hFFFF, 1'b1});
        chk("b2b_2", {15'd0, beat_log[2].data, beat_log[2].ext}, {15'd0, 16'h0001, 1'b0});
        chk("b2b_3", {15'd0, beat_log[3].data, beat_log[3].ext}, {15'd0, 16'h0000, 1'b0});
      end
    end else begin
      chk("b2b_nbeats", beat_log.size(), 6);
    end
    for (int k = 1; k < beat_log.size(); k++)
      chk("b2b_no_bubble", beat_log[k].cyc, beat_log[0].cyc + k);
    chk("b2b_cnt_words", {16'd0, cnt_words}, 32'd3);
    chk("b2b_cnt_comp", {16'd0, cnt_comp}, COMP_ON ? 32'd2 : 32'd0);

    // saturation on the CNT_W=2 instance
    acc = 0;
    guard = 0;
    while (acc < 5 && guard < 100) begin
      s_in_valid = 1'b1;
      s_in_data  = 32'h00000010 + acc;
      @(negedge clk);
      if (s_in_ready) acc++;
      next_cycle();
      guard++;
    end
    s_in_valid = 1'b0;
    chk("sat_accepted", acc, 5);
    repeat (3) next_cycle();
    chk("sat_cnt_words", {30'd0, s_cnt_words}, 32'd3);
    chk("sat_cnt_comp", {30'd0, s_cnt_comp}, COMP_ON ? 32'd3 : 32'd0);

    // randomized traffic against the reference model
    for (int r = 0; r < 600; r++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       in_data = {17'h00000, 15'($urandom)};
        1:       in_data = {17'h1FFFF, 15'($urandom)};
        default: in_data = $urandom;
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      next_cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      next_cycle();
      guard++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (2) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sext_compress_serializer.md
Name: sext_compress_serializer

Overview:
- Inverse of the 16-to-32 sign extender: accepts 32-bit words and emits them on a 16-bit stream.
- A word that is exactly the sign extension of its low half goes out as one tagged beat. Any other word goes out as two raw beats, high half first.
- Sits between the datapath and a narrow 16-bit link or trace port.
- A downstream sign extender rebuilds the original word from the tagged beat.

Parameters:
- CNT_W, 16, width of the statistics counters (saturating).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  32  word to serialize.
- out_valid  output  1  out_data/out_ext/out_last valid.
- out_ready  input  1  consumer accepts the current beat.
- out_data  output  16  beat payload.
- out_ext  output  1  1 = beat is a compressed word; consumer sign-extends it to 32 bits.
- out_last  output  1  final beat of the current word.
- cnt_words  output  CNT_W  words accepted since reset, saturating.
- cnt_comp  output  CNT_W  words sent compressed since reset, saturating.

Behaviour:
- Reset (rst_n low at a clk edge) has priority over everything and is synchronous. It forces:
  - state = IDLE
  - out_valid = 0, out_data = 0, out_ext = 0, out_last = 0
  - cnt_words = 0, cnt_comp = 0
  - holding register = 0
- Reset asserted mid-word drops any partial word; no further beats of it are emitted.
- Compressible test: in_data[31:15] all zeros or all ones.
- FSM states:
  - IDLE: out_valid = 0, in_ready = 1. An accepted word (in_valid & in_ready) is latched.
    - Compressible: go to SEND_EXT; out_data = in_data[15:0], out_ext = 1, out_last = 1.
    - Otherwise: go to SEND_HI; out_data = in_data[31:16], out_ext = 0, out_last = 0.
  - SEND_EXT: out_valid = 1. When out_ready is high, the beat completes.
  - SEND_HI: out_valid = 1. When out_ready is high, go to SEND_LO; out_data = hold[15:0], out_ext = 0, out_last = 1.
  - SEND_LO: out_valid = 1. When out_ready is high, the beat completes.
- Completing a final beat (SEND_EXT or SEND_LO):
  - in_ready = out_ready in these states, so a new word may be accepted in the same cycle.
  - If a word is accepted in that cycle, go directly to SEND_EXT or SEND_HI per the new word; no bubble.
  - If no word is accepted, go to IDLE.
- in_ready = 0 in SEND_HI.
- Latency: word accepted at edge N gives its first beat valid after edge N (registered output).
- Throughput:
  - 1 compressed word per cycle.
  - 1 uncompressed word per 2 cycles.
- Stability: while out_valid & !out_ready, out_data, out_ext and out_last hold stable.
- Counters:
  - cnt_words increments on each accepted word.
  - cnt_comp increments on each accepted compressible word.
  - Both saturate at all-ones; no wrap.

Optional Feature:
- Macro SEXT_COMPRESS_EN.
- Defined: behaviour as above.
- Undefined:
  - Compressible test is forced false; every word takes two beats.
  - out_ext is tied to 0.
  - cnt_comp is tied to 0.
  - cnt_words still counts.

Decomposition:
- Shared package sext_pkg holds:
  - the state enum (IDLE, SEND_EXT, SEND_HI, SEND_LO)
  - localparams WORD_W = 32 and HALF_W = 16
  - a function is_sext16(word) returning the compressible test
- One natural sub-module: sat_counter (CNT_W, inc, clear) → instantiated twice.
- The existing signExtend16to32 serves as the bench reference model for compressed beats.

Test Plan:
- Reset check: hold rst_n low 2 cycles during an active SEND_HI.
  - Required: all outputs 0, counters 0, no SEND_LO beat after release.
- Positive compressible word: in_data = 0x00007B95, out_ready = 1.
  - Required: one beat, out_data = 0x7B95, out_ext = 1, out_last = 1, cnt_comp = 1.
- Negative compressible word: in_data = 0xFFFFFB95.
  - Required: one beat, out_data = 0xFB95, out_ext = 1.
  - Sign-extending that beat gives 0xFFFFFB95.
- Non-compressible word with stall: in_data = 0x12348000, out_ready low for 3 cycles, then high.
  - Required: beat 0x1234 (ext 0, last 0) held stable through the stall, then 0x8000 (ext 0, last 1).
  - cnt_comp unchanged.
- Back-to-back stream: in_valid held high with 0x00000001, 0xFFFFFFFF, 0x00010000, out_ready = 1.
  - Required: beats 0x0001(e), 0xFFFF(e), 0x0001, 0x0000 on 4 consecutive cycles, no bubbles.
  - cnt_words = 3, cnt_comp = 2.
- Saturation and macro-off build:
  - CNT_W = 2, 5 compressible words → both counters end at 3.
  - Without SEXT_COMPRESS_EN, 0x00007B95 → beats 0x0000 then 0x7B95, out_ext = 0.
